mult_rr_scheduler: RTL and testbench

//  Shares one vdic_dut_2023 signed 16x16 multiplier among N_REQ requesters.

---
 rtl/mult_sched_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/mult_rr_scheduler.sv | 132 +++++++++++++
 tb/tb_mult_rr_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types for the multiplier round-robin scheduler: FSM states, response
// status codes and the operand/response bundles moved between client and multiplier.
package mult_sched_pkg;

    localparam int ARG_W = 16;
    localparam int RES_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        RESP     = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_PERR    = 2'b01,
        ST_TIMEOUT = 2'b10
    } sched_status_t;

    typedef struct packed {
        logic [ARG_W-1:0] a;
        logic             a_par;
        logic [ARG_W-1:0] b;
        logic             b_par;
    } mult_args_t;

    typedef struct packed {
        logic [RES_W-1:0] result;
        logic             parity;
        sched_status_t    status;
    } sched_resp_t;

    // Index width that stays legal (>=1 bit) for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first active request at or after
// ptr, wrapping past N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int            s;
    logic [IW-1:0] cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        s    = 0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            s = int'(ptr) + k;
            if (s >= N) s = s - N;
            cand = s[IW-1:0];
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Time-shares one signed 16x16 multiplier (req/ack/result_rdy handshake) among
// N_REQ requesters, round-robin, and returns each response to its owner.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       rq_req,
    input  logic [ARG_W*N_REQ-1:0] rq_arg_a,
    input  logic [N_REQ-1:0]       rq_arg_a_parity,
    input  logic [ARG_W*N_REQ-1:0] rq_arg_b,
    input  logic [N_REQ-1:0]       rq_arg_b_parity,
    output logic [N_REQ-1:0]       rq_done,
    output logic [RES_W-1:0]       rq_result,
    output logic                   rq_result_parity,
    output logic [1:0]             rq_status,
    output logic                   mult_req,
    output logic [ARG_W-1:0]       mult_arg_a,
    output logic                   mult_arg_a_parity,
    output logic [ARG_W-1:0]       mult_arg_b,
    output logic                   mult_arg_b_parity,
    input  logic                   mult_ack,
    input  logic [RES_W-1:0]       mult_result,
    input  logic                   mult_result_parity,
    input  logic                   mult_result_rdy,
    input  logic                   mult_arg_parity_error
);

    localparam int IW = idx_width(N_REQ);
    localparam int CW = idx_width(TIMEOUT);

    logic [N_REQ-1:0][ARG_W-1:0] arg_a_v, arg_b_v;
    assign arg_a_v = rq_arg_a;
    assign arg_b_v = rq_arg_b;

    sched_state_t     state;
    logic [IW-1:0]    ptr, g;
    logic [N_REQ-1:0] gnt_q;
    logic [CW-1:0]    tmo_cnt;
    mult_args_t       args_q;
    sched_resp_t      resp_q, resp_d;
    logic             busy, tmo_hit, finish;

    logic [N_REQ-1:0] arb_gnt;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req (rq_req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    assign busy    = (state == ISSUE) || (state == WAIT_RDY);
    assign tmo_hit = busy && (tmo_cnt == CW'(TIMEOUT - 1));

    // A result in WAIT_RDY beats a coincident timeout; ack+rdy together in ISSUE
    // counts as ack only, so the early rdy is ignored here.
    always_comb begin
        finish = 1'b0;
        resp_d = '0;
        if (state == WAIT_RDY && mult_result_rdy) begin
            finish        = 1'b1;
            resp_d.result = mult_result;
            resp_d.parity = mult_result_parity;
            resp_d.status = mult_arg_parity_error ? ST_PERR : ST_OK;
        end else if (tmo_hit) begin
            finish        = 1'b1;
            resp_d.status = ST_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            gnt_q    <= '0;
            tmo_cnt  <= '0;
            args_q   <= '0;
            resp_q   <= '0;
            mult_req <= 1'b0;
            rq_done  <= '0;
        end else begin
            if (busy) tmo_cnt <= tmo_cnt + CW'(1);
            if (finish) begin
                mult_req <= 1'b0;
                resp_q   <= resp_d;
                rq_done  <= gnt_q;
                state    <= RESP;
            end else begin
                case (state)
                    IDLE: if (arb_any) begin
                        g            <= arb_idx;
                        gnt_q        <= arb_gnt;
                        args_q.a     <= arg_a_v[arb_idx];
                        args_q.a_par <= rq_arg_a_parity[arb_idx];
                        args_q.b     <= arg_b_v[arb_idx];
                        args_q.b_par <= rq_arg_b_parity[arb_idx];
                        tmo_cnt      <= '0;
                        mult_req     <= 1'b1;
                        state        <= ISSUE;
                    end
                    ISSUE: if (mult_ack) begin
                        mult_req <= 1'b0;
                        state    <= WAIT_RDY;
                    end
                    RESP: begin
                        rq_done <= '0;
                        ptr     <= (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
                        state   <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mult_arg_a        = args_q.a;
    assign mult_arg_a_parity = args_q.a_par;
    assign mult_arg_b        = args_q.b;
    assign mult_arg_b_parity = args_q.b_par;
    assign rq_result         = resp_q.result;
    assign rq_result_parity  = resp_q.parity;
    assign rq_status         = resp_q.status;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: behavioural multiplier stub plus directed and
// randomized traffic checked against a round-robin reference model.
module tb_mult_rr_scheduler;

    localparam int N   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    rq_req;
    logic [16*N-1:0] rq_arg_a, rq_arg_b;
    logic [N-1:0]    rq_arg_a_parity, rq_arg_b_parity;
    logic [N-1:0]    rq_done;
    logic [31:0]     rq_result;
    logic            rq_result_parity;
    logic [1:0]      rq_status;
    logic            mult_req;
    logic [15:0]     mult_arg_a, mult_arg_b;
    logic            mult_arg_a_parity, mult_arg_b_parity;
    logic            mult_ack, mult_result_parity, mult_result_rdy, mult_arg_parity_error;
    logic [31:0]     mult_result;

    mult_rr_scheduler #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .rq_req               (rq_req),
        .rq_arg_a             (rq_arg_a),
        .rq_arg_a_parity      (rq_arg_a_parity),
        .rq_arg_b             (rq_arg_b),
        .rq_arg_b_parity      (rq_arg_b_parity),
        .rq_done              (rq_done),
        .rq_result            (rq_result),
        .rq_result_parity     (rq_result_parity),
        .rq_status            (rq_status),
        .mult_req             (mult_req),
        .mult_arg_a           (mult_arg_a),
        .mult_arg_a_parity    (mult_arg_a_parity),
        .mult_arg_b           (mult_arg_b),
        .mult_arg_b_parity    (mult_arg_b_parity),
        .mult_ack             (mult_ack),
        .mult_result          (mult_result),
        .mult_result_parity   (mult_result_parity),
        .mult_result_rdy      (mult_result_rdy),
        .mult_arg_parity_error(mult_arg_parity_error)
    );

    // Multiplier stub. mode: 0 normal, 1 never result_rdy, 2 ack+bogus rdy together, 3 mix of 0/2.
    int          mode;
    int          st, scnt;
    logic [15:0] sa, sb;
    logic        spa, spb, s_perr;
    logic signed [31:0] s_a32, s_b32, s_res;

    always_comb begin
        s_a32  = $signed(sa);
        s_b32  = $signed(sb);
        s_perr = (spa != ^sa) || (spb != ^sb);
        s_res  = s_perr ? 32'sd0 : s_a32 * s_b32;
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= 0; scnt <= 0; sa <= '0; sb <= '0; spa <= 1'b0; spb <= 1'b0;
            mult_ack <= 1'b0; mult_result_rdy <= 1'b0; mult_result <= '0;
            mult_result_parity <= 1'b0; mult_arg_parity_error <= 1'b0;
        end else begin
            case (st)
                0: begin
                    mult_result_rdy <= 1'b0;
                    if (mult_req) begin
                        sa <= mult_arg_a; sb <= mult_arg_b;
                        spa <= mult_arg_a_parity; spb <= mult_arg_b_parity;
                        scnt <= int'($urandom_range(1, 0));
                        st <= 1;
                    end
                end
                1: if (scnt == 0) begin
                    mult_ack <= 1'b1;
                    st <= 2;
                    if (mode == 2 || (mode == 3 && $urandom_range(1, 0) == 1)) begin
                        mult_result_rdy    <= 1'b1;
                        mult_result        <= 32'hDEAD_BEEF;
                        mult_result_parity <= 1'b1;
                    end
                end else scnt <= scnt - 1;
                2: begin
                    mult_ack <= 1'b0;
                    mult_result_rdy <= 1'b0;
                    scnt <= int'($urandom_range(2, 0));
                    st <= (mode == 1) ? 0 : 3;
                end
                3: if (scnt == 0) begin
                    mult_result_rdy       <= 1'b1;
                    mult_result           <= s_res;
                    mult_result_parity    <= ^s_res;
                    mult_arg_parity_error <= s_perr;
                    st <= 4;
                end else scnt <= scnt - 1;
                default: begin
                    mult_result_rdy <= 1'b0;
                    st <= 0;
                end
            endcase
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] op_a[N], op_b[N];
    logic        pa[N], pb[N];

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic bad_a, input logic bad_b);
        op_a[i] = a; op_b[i] = b;
        pa[i] = (^a) ^ bad_a;
        pb[i] = (^b) ^ bad_b;
        rq_arg_a[16*i +: 16] = a;
        rq_arg_b[16*i +: 16] = b;
        rq_arg_a_parity[i] = pa[i];
        rq_arg_b_parity[i] = pb[i];
    endtask

    task automatic rand_req(input int i);
        set_req(i, 16'($urandom), 16'($urandom),
                $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0);
    endtask

    // Reference response for requester i: product of its operands unless a parity bit lies.
    task automatic check_resp(input string tag, input int i);
        logic signed [31:0] a32, b32;
        logic [31:0] er;
        logic pe;
        a32 = $signed(op_a[i]);
        b32 = $signed(op_b[i]);
        pe  = (pa[i] != ^op_a[i]) || (pb[i] != ^op_b[i]);
        er  = pe ? 32'd0 : 32'(a32 * b32);
        chk({tag, "_res"}, rq_result, er);
        chk({tag, "_par"}, {31'd0, rq_result_parity}, {31'd0, ^er});
        chk({tag, "_st"}, {30'd0, rq_status}, pe ? 32'd1 : 32'd0);
    endtask

    task automatic wait_done(input int maxc, output int idx, output int cyc);
        idx = -1;
        cyc = 0;
        while (idx < 0 && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (rq_done != '0) begin
                chk("done_onehot", $countones(rq_done), 1);
                for (int i = N - 1; i >= 0; i--) if (rq_done[i]) idx = i;
            end
        end
        if (idx < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int idx, cyc, cnt, exp_g, mptr, since;
        bit arb_open, arb_skip;
        rq_req = '0; rq_arg_a = '0; rq_arg_b = '0;
        rq_arg_a_parity = '0; rq_arg_b_parity = '0;
        mode = 0;
        for (int i = 0; i < N; i++) set_req(i, 16'd0, 16'd0, 1'b0, 1'b0);
        do_reset();

        chk("rst_done", {28'd0, rq_done}, 0);
        chk("rst_result", rq_result, 0);
        chk("rst_status", {30'd0, rq_status}, 0);
        chk("rst_mreq", {31'd0, mult_req}, 0);
        chk("rst_margs", {mult_arg_a, mult_arg_b}, 0);

        // Single request: 3 * -5.
        set_req(0, 16'd3, 16'hFFFB, 1'b0, 1'b0);
        rq_req[0] = 1'b1;
        wait_done(40, idx, cyc);
        chk("single_idx", idx, 0);
        check_resp("single", 0);
        chk("single_val", rq_result, 32'hFFFF_FFF1);
        rq_req[0] = 1'b0;
        @(negedge clk);
        chk("single_pulse", {28'd0, rq_done}, 0);

        // Wrong A parity bit.
        set_req(1, 16'h0001, 16'h0007, 1'b1, 1'b0);
        rq_req[1] = 1'b1;
        wait_done(40, idx, cyc);
        chk("perr_idx", idx, 1);
        check_resp("perr", 1);
        chk("perr_status", {30'd0, rq_status}, 1);
        rq_req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: all requesters high from reset.
        for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        rq_req = '1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_done(40, idx, cyc);
            chk("cont_idx", idx, k % N);
            if (idx >= 0) begin
                check_resp("cont", idx);
                set_req(idx, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            end
        end
        rq_req = '0;
        repeat (3) @(negedge clk);

        // Fairness: rq0 arrives after rq2 is granted; rq2 stays high.
        do_reset();
        set_req(2, 16'd100, 16'hFF00, 1'b0, 1'b0);
        rq_req[2] = 1'b1;
        cnt = 0;
        while (!mult_req && cnt < 10) begin @(negedge clk); cnt++; end
        chk("fair_mreq", {31'd0, mult_req}, 1);
        set_req(0, 16'd7, 16'd9, 1'b0, 1'b0);
        rq_req[0] = 1'b1;
        wait_done(40, idx, cyc);
        chk("fair_idx0", idx, 2);
        check_resp("fair_a", 2);
        set_req(2, 16'd11, 16'd13, 1'b0, 1'b0);
        wait_done(40, idx, cyc);
        chk("fair_idx1", idx, 0);
        check_resp("fair_b", 0);
        rq_req[0] = 1'b0;
        wait_done(40, idx, cyc);
        chk("fair_idx2", idx, 2);
        check_resp("fair_c", 2);
        rq_req = '0;
        repeat (3) @(negedge clk);

        // Timeout: result_rdy never comes.
        mode = 1;
        set_req(3, 16'd5, 16'd6, 1'b0, 1'b0);
        rq_req[3] = 1'b1;
        wait_done(40, idx, cyc);
        chk("tmo_idx", idx, 3);
        chk("tmo_status", {30'd0, rq_status}, 2);
        chk("tmo_result", rq_result, 0);
        chk("tmo_par", {31'd0, rq_result_parity}, 0);
        chk("tmo_latency", cyc, TMO + 1);
        rq_req[3] = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);

        // Ack and a bogus rdy in the same cycle: only the later rdy counts.
        mode = 2;
        set_req(1, 16'h1234, 16'h0100, 1'b0, 1'b0);
        rq_req[1] = 1'b1;
        wait_done(40, idx, cyc);
        chk("ackrdy_idx", idx, 1);
        check_resp("ackrdy", 1);
        rq_req[1] = 1'b0;
        mode = 0;
        repeat (3) @(negedge clk);

        // Reset while waiting for result_rdy.
        mode = 1;
        set_req(2, 16'd21, 16'd2, 1'b0, 1'b0);
        rq_req[2] = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        rq_req = '0;
        #1;
        chk("mrst_done", {28'd0, rq_done}, 0);
        chk("mrst_result", rq_result, 0);
        chk("mrst_status", {30'd0, rq_status}, 0);
        chk("mrst_mreq", {31'd0, mult_req}, 0);
        chk("mrst_margs", {mult_arg_a, mult_arg_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        cnt = 0;
        repeat (12) begin @(negedge clk); if (rq_done != '0) cnt++; end
        chk("mrst_no_done", cnt, 0);
        set_req(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        set_req(3, 16'h7FFF, 16'h8000, 1'b0, 1'b0);
        rq_req[1] = 1'b1;
        rq_req[3] = 1'b1;
        wait_done(40, idx, cyc);
        chk("mrst_idx1", idx, 1);
        check_resp("mrst_a", 1);
        rq_req[1] = 1'b0;
        wait_done(40, idx, cyc);
        chk("mrst_idx3", idx, 3);
        check_resp("mrst_b", 3);
        rq_req = '0;
        repeat (3) @(negedge clk);

        // Randomized traffic against the round-robin model. The scheduler decides
        // on the request vector seen one full cycle after a completion.
        do_reset();
        mode = 3;
        mptr = 0; exp_g = -1; arb_open = 1'b1; arb_skip = 1'b0; since = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rq_done != '0) begin
                chk("rnd_onehot", $countones(rq_done), 1);
                idx = -1;
                for (int i = N - 1; i >= 0; i--) if (rq_done[i]) idx = i;
                chk("rnd_grant", idx, exp_g);
                if (idx >= 0) begin
                    check_resp("rnd", idx);
                    if ($urandom_range(1, 0) == 1) rand_req(idx);
                    else rq_req[idx] = 1'b0;
                end
                if (exp_g >= 0) mptr = (exp_g + 1) % N;
                exp_g = -1; arb_open = 1'b1; arb_skip = 1'b1; since = 0;
            end
            for (int i = 0; i < N; i++)
                if (!rq_req[i] && $urandom_range(5, 0) == 0) begin
                    rand_req(i);
                    rq_req[i] = 1'b1;
                end
            if (arb_open) begin
                if (arb_skip) arb_skip = 1'b0;
                else if (rq_req != '0) begin
                    exp_g = pick(rq_req, mptr);
                    arb_open = 1'b0;
                end
            end
            if (rq_req != '0) since++;
            if (since > 40) begin
                chk("rnd_stall", since, 0);
                break;
            end
        end
        rq_req = '0;
        mode = 0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
